// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver and scan-code set 2 decoder for the calculator keypad.
// Emits one key_valid pulse per new make code of a mapped key, ignoring typematic repeats.
module ps2_key_decoder #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [10:0] key_code,
  output logic        key_valid,
  output logic        frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic          kclk_s1_q, kclk_s2_q, kdat_s1_q, kdat_s2_q;
  logic          filt_q;
  logic [FW-1:0] fcnt_q;
  logic          fall_w;
  state_t        state_q, state_d;
  logic [2:0]    bitcnt_q;
  logic [7:0]    shreg_q;
  logic          par_q;
  logic [TW-1:0] tocnt_q;
  logic          to_w, good_w, byte_done_w, err_w;
  logic          ext_q, brk_q, held_vld_q;
  logic [8:0]    held_q, code_w;
  logic [4:0]    map_w;
  logic          repeat_w, plain_w, emit_w;
  logic [10:0]   key_code_q;
  logic          key_valid_q, frame_err_q;

  // Returns {mapped, value} for an {ext, byte} scan code.
  function automatic logic [4:0] map_key(input logic [8:0] c);
    case (c)
      9'h045, 9'h070: map_key = {1'b1, 4'd0};
      9'h016, 9'h069: map_key = {1'b1, 4'd1};
      9'h01E, 9'h072: map_key = {1'b1, 4'd2};
      9'h026, 9'h07A: map_key = {1'b1, 4'd3};
      9'h025, 9'h06B: map_key = {1'b1, 4'd4};
      9'h02E, 9'h073: map_key = {1'b1, 4'd5};
      9'h036, 9'h074: map_key = {1'b1, 4'd6};
      9'h03D, 9'h06C: map_key = {1'b1, 4'd7};
      9'h03E, 9'h075: map_key = {1'b1, 4'd8};
      9'h046, 9'h07D: map_key = {1'b1, 4'd9};
      9'h079:         map_key = {1'b1, 4'd10};
      9'h07B, 9'h04E: map_key = {1'b1, 4'd11};
      9'h07C:         map_key = {1'b1, 4'd12};
      9'h14A:         map_key = {1'b1, 4'd13};
      9'h05A, 9'h15A: map_key = {1'b1, 4'd14};
      default:        map_key = 5'd0;
    endcase
  endfunction

  // Input synchronizers; lines idle high.
  always_ff @(posedge clk) begin
    if (rst) begin
      kclk_s1_q <= 1'b1;
      kclk_s2_q <= 1'b1;
      kdat_s1_q <= 1'b1;
      kdat_s2_q <= 1'b1;
    end else begin
      kclk_s1_q <= ps2_clk;
      kclk_s2_q <= kclk_s1_q;
      kdat_s1_q <= ps2_data;
      kdat_s2_q <= kdat_s1_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      filt_q <= 1'b1;
      fcnt_q <= '0;
    end else if (kclk_s2_q == filt_q) begin
      fcnt_q <= '0;
    end else if (fcnt_q == FW'(FILTER_LEN - 1)) begin
      filt_q <= ~filt_q;
      fcnt_q <= '0;
    end else begin
      fcnt_q <= fcnt_q + FW'(1);
    end
  end

  // A fall is the cycle in which the filtered level is about to flip from 1 to 0.
  assign fall_w = filt_q && (kclk_s2_q != filt_q) && (fcnt_q == FW'(FILTER_LEN - 1));
  assign to_w   = (state_q != IDLE) && !fall_w && (tocnt_q == TW'(TIMEOUT_CYCLES - 1));
  assign good_w = kdat_s2_q && (^{par_q, shreg_q});

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (to_w) begin
      state_d = IDLE;
    end else if (fall_w) begin
      case (state_q)
        IDLE:    if (!kdat_s2_q) state_d = DATA;
        DATA:    if (bitcnt_q == 3'd7) state_d = PARITY;
        PARITY:  state_d = STOP;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    byte_done_w = 1'b0;
    err_w       = to_w;
    if ((state_q == STOP) && fall_w) begin
      byte_done_w = good_w;
      err_w       = !good_w;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bitcnt_q <= '0;
      tocnt_q  <= '0;
    end else begin
      if ((state_q == IDLE) || fall_w || to_w) tocnt_q <= '0;
      else                                     tocnt_q <= tocnt_q + TW'(1);
      if (fall_w && (state_q == IDLE)) bitcnt_q <= '0;
      if (fall_w && (state_q == DATA)) bitcnt_q <= bitcnt_q + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (fall_w && (state_q == DATA))   shreg_q <= {kdat_s2_q, shreg_q[7:1]};
    if (fall_w && (state_q == PARITY)) par_q   <= kdat_s2_q;
  end

  // Decoder: prefixes, break handling and held-key repeat suppression.
  assign code_w   = {ext_q, shreg_q};
  assign map_w    = map_key(code_w);
  assign repeat_w = held_vld_q && (held_q == code_w);
  assign plain_w  = byte_done_w && (shreg_q != 8'hE0) && (shreg_q != 8'hF0);
  assign emit_w   = plain_w && !brk_q && map_w[4] && !repeat_w;

  always_ff @(posedge clk) begin
    if (rst) begin
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      held_vld_q  <= 1'b0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      key_valid_q <= emit_w;
      frame_err_q <= err_w;
      if (err_w) begin
        ext_q <= 1'b0;
        brk_q <= 1'b0;
      end else if (byte_done_w && (shreg_q == 8'hE0)) begin
        ext_q <= 1'b1;
      end else if (byte_done_w && (shreg_q == 8'hF0)) begin
        brk_q <= 1'b1;
      end else if (plain_w) begin
        ext_q <= 1'b0;
        brk_q <= 1'b0;
        if (brk_q && repeat_w) held_vld_q <= 1'b0;
        if (emit_w) begin
          held_vld_q <= 1'b1;
          key_code_q <= {7'd0, map_w[3:0]};
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (emit_w) held_q <= code_w;
  end

  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Bench for ps2_key_decoder: drives PS/2 frames and scoreboards decoded keys.
module tb_ps2_key_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic [10:0] key_code;
  logic        key_valid;
  logic        frame_err;

  int          total = 0;
  int          bad = 0;
  int          kv_cnt = 0;
  int          err_cnt = 0;
  logic        prev_kv = 1'b0;
  logic [10:0] exp_q[$];
  logic [10:0] exp_code;

  always #5 clk = ~clk;

  ps2_key_decoder #(.FILTER_LEN(8), .TIMEOUT_CYCLES(200)) dut (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .key_code  (key_code),
    .key_valid (key_valid),
    .frame_err (frame_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    ps2_data = b;
    cyc(15);
    ps2_clk = 1'b0;
    cyc(20);
    ps2_clk = 1'b1;
    cyc(15);
  endtask

  // Sends the first nbits of a frame; bad_par inverts the odd-parity bit.
  task automatic send_frame(input logic [7:0] d, input logic bad_par, input int nbits);
    logic [10:0] f;
    f = {1'b1, (~^d) ^ bad_par, d, 1'b0};
    for (int i = 0; i < nbits; i++) send_bit(f[i]);
    ps2_data = 1'b1;
  endtask

  task automatic quiet(input logic [7:0] d);
    send_frame(d, 1'b0, 11);
  endtask

  task automatic make(input logic [7:0] d, input logic [10:0] code);
    exp_q.push_back(code);
    send_frame(d, 1'b0, 11);
  endtask

  always @(negedge clk) begin
    if (key_valid) begin
      kv_cnt++;
      chk("kv_with_err", frame_err, 0);
      chk("kv_back_to_back", prev_kv, 0);
      chk("sb_pending", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        exp_code = exp_q.pop_front();
        chk("key_code", key_code, exp_code);
      end
    end
    if (frame_err) err_cnt++;
    prev_kv = key_valid;
  end

  initial begin
    rst = 1'b1;
    cyc(4);
    chk("rst_key_code", key_code, 0);
    chk("rst_key_valid", key_valid, 0);
    chk("rst_frame_err", frame_err, 0);
    rst = 1'b0;
    cyc(10);

    // make then break of the same key
    make(8'h1E, 11'd2);
    quiet(8'hF0);
    quiet(8'h1E);
    cyc(5);
    chk("t1_err_cnt", err_cnt, 0);
    chk("t1_kv_cnt", kv_cnt, 1);

    // extended keys
    quiet(8'hE0);
    make(8'h4A, 11'd13);
    quiet(8'hE0);
    quiet(8'hF0);
    quiet(8'h4A);
    make(8'h5A, 11'd14);
    chk("t2_kv_cnt", kv_cnt, 3);

    // typematic repeat suppression
    make(8'h16, 11'd1);
    quiet(8'h16);
    quiet(8'h16);
    quiet(8'hF0);
    quiet(8'h16);
    make(8'h16, 11'd1);
    cyc(5);
    chk("t3_kv_cnt", kv_cnt, 5);

    // parity error
    send_frame(8'h79, 1'b1, 11);
    cyc(5);
    chk("t4_err_cnt", err_cnt, 1);
    chk("t4_kv_cnt", kv_cnt, 5);
    make(8'h79, 11'd10);
    chk("t4b_kv_cnt", kv_cnt, 6);

    // timeout after start + 4 data bits
    send_frame(8'h7C, 1'b0, 5);
    cyc(250);
    chk("t5_err_cnt", err_cnt, 2);
    make(8'h7C, 11'd12);
    chk("t5_kv_cnt", kv_cnt, 7);

    // short glitch on ps2_clk while idle with data low
    ps2_data = 1'b0;
    cyc(2);
    ps2_clk = 1'b0;
    cyc(3);
    ps2_clk = 1'b1;
    cyc(2);
    ps2_data = 1'b1;
    cyc(20);
    make(8'h3E, 11'd8);
    chk("t6_err_cnt", err_cnt, 2);
    chk("t6_kv_cnt", kv_cnt, 8);

    // unmapped extended code, keypad keys
    quiet(8'hE0);
    quiet(8'h70);
    make(8'h7A, 11'd3);
    make(8'h7B, 11'd11);
    chk("t7_kv_cnt", kv_cnt, 10);

    // reset in the middle of a frame
    send_frame(8'h45, 1'b0, 4);
    rst = 1'b1;
    cyc(3);
    chk("rst2_key_code", key_code, 0);
    chk("rst2_key_valid", key_valid, 0);
    chk("rst2_frame_err", frame_err, 0);
    rst = 1'b0;
    cyc(5);
    make(8'h45, 11'd0);
    cyc(10);
    chk("t8_kv_cnt", kv_cnt, 11);
    chk("t8_err_cnt", err_cnt, 2);
    chk("sb_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ps2_key_decoder.md
Name: ps2_key_decoder

Overview:
- Upstream stage of the calculator operator block (`xoper`).
- Receives PS/2 keyboard frames on the raw `ps2_clk`/`ps2_data` lines and decodes scan-code set 2 sequences: E0 extended prefix, F0 break prefix, and typematic repeat.
- Emits a one-cycle `key_valid` strobe with an 11-bit `key_code` in 0..14: 0-9 digits, 10 '+', 11 '-', 12 '*', 13 '/', 14 Enter.
- `key_valid` drives the operator's `sel`; `key_code` drives its `data_in`.

Parameters:
- FILTER_LEN, 8: number of consecutive equal synchronized samples required before the filtered `ps2_clk` changes level.
- TIMEOUT_CYCLES, 50000: `clk` cycles without a filtered `ps2_clk` falling edge, inside a frame, before the frame is aborted (1 ms at 50 MHz).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- ps2_clk  input  1  raw PS/2 clock, asynchronous
- ps2_data  input  1  raw PS/2 data, asynchronous
- key_code  output  11  decoded key, 0..14, upper bits 0; holds last value
- key_valid  output  1  one-cycle pulse, `key_code` valid
- frame_err  output  1  one-cycle pulse on parity, stop or timeout error

Behaviour:
- Reset values: `key_code` = 0, `key_valid` = 0, `frame_err` = 0, receiver state IDLE, ext = 0, brk = 0, held_valid = 0, filter and timeout counters = 0.
- Reset applies on any edge where `rst` = 1 and aborts any partial frame.
- Synchronizers: `ps2_clk` and `ps2_data` each pass through 2 flip-flops.
- Clock filter: a counter runs while the synchronized `ps2_clk` differs from the filtered level. When it reaches FILTER_LEN, the filtered level flips and the counter clears. Any agreeing sample also clears the counter.
- Edge detect: a filtered 1->0 transition is a "fall". Synchronized data is sampled in that same cycle.
- Receiver FSM:
  - IDLE: on a fall with data = 0, go to DATA with bit count 0. A fall with data = 1 is ignored.
  - DATA: each fall shifts data in LSB-first. After 8 bits, go to PARITY.
  - PARITY: latch the parity bit, go to STOP.
  - STOP: on a fall, the frame is good if stop = 1 and the 9 bits (8 data + parity) hold an odd number of ones. A good frame gives a one-cycle internal byte_done pulse. A bad frame gives `frame_err` = 1 for one cycle, clears ext and brk, and discards the byte. Either way, return to IDLE.
- Timeout: while not IDLE, a counter increments every `clk` and clears on each fall. At TIMEOUT_CYCLES: return to IDLE, pulse `frame_err`, clear ext and brk.
- Decoder, evaluated on byte_done:
  - byte E0: set ext = 1.
  - byte F0: set brk = 1.
  - otherwise, with brk = 1: if held_valid and held == {ext, byte}, clear held_valid. Clear ext and brk. No output.
  - otherwise, make code: look up {ext, byte}.
    - If mapped and not (held_valid and held == {ext, byte}): `key_code` <= mapped value, `key_valid` <= 1 in the next cycle, held <= {ext, byte}, held_valid = 1.
    - Unmapped codes or repeats: no output.
    - Clear ext and brk.
- Latency: `key_valid` rises exactly 1 `clk` after the byte_done cycle, lasts 1 cycle, and is never asserted in two consecutive cycles.
- Map, non-extended:
  - top-row digits 0-9 = 45, 16, 1E, 26, 25, 2E, 36, 3D, 3E, 46
  - keypad digits 0-9 = 70, 69, 72, 7A, 6B, 73, 74, 6C, 75, 7D
  - 79 -> 10; 7B and 4E -> 11; 7C -> 12; 5A -> 14
- Map, extended: E0 4A -> 13; E0 5A -> 14. Every other extended code is unmapped.
- Only one held key is tracked. A new mapped make from a different key replaces held and is emitted.
- `frame_err` and `key_valid` never assert together: an errored frame produces no key.

Test Plan:
- Frame 1E with odd parity (parity bit 1), then break F0 1E -> one `key_valid` pulse with `key_code` = 2; no pulse on the break; `frame_err` stays 0.
- Sequence E0 4A, then E0 F0 4A -> `key_code` = 13 pulsed once. Then 5A -> `key_code` = 14.
- Typematic: 16, 16, 16, then F0 16, then 16 -> exactly two pulses, both `key_code` = 1.
- Frame 79 with wrong parity bit -> `frame_err` pulses once, no `key_valid`. A following good 79 -> `key_code` = 10.
- Stop `ps2_clk` after 4 data bits for TIMEOUT_CYCLES (set to 200 in the bench) -> `frame_err` pulse, FSM back in IDLE. Next full frame 7C -> `key_code` = 12.
- Glitch: 3-cycle low pulse on `ps2_clk` (< FILTER_LEN) in IDLE -> no state change. Assert `rst` mid-frame, then send 45 -> `key_code` = 0 with a `key_valid` pulse; all outputs were 0 during reset.
